// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch types and widths.
// Holds XLEN, instruction width, reset PC default and fetch_entry_t.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Fetch buffer: synchronous FIFO with push/pop/flush and occupancy count.
// Ports: clk_i, rst_i, flush_i, push_i, pop_i, wdata_i, rdata_o,
//        count_o, full_o, empty_o. Head entry is visible as rdata_o.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, cache request, miss/discard tracking, buffer.
// In: clk, rst, redirect_valid/pc, fence_i, ic_data/valid/stall, dec_ready.
// Out: ic_addr, ic_req, ic_invalidate, dec_valid, dec_instr, dec_pc.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fence_i,
  output logic [XLEN-1:0] ic_addr,
  output logic            ic_req,
  input  logic [ILEN-1:0] ic_data,
  input  logic            ic_valid,
  input  logic            ic_stall,
  output logic            ic_invalidate,
  output logic            dec_valid,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            miss_q, miss_d;
  logic            disc_q, disc_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  fetch_entry_t    wentry;
  fetch_entry_t    head;
  logic [$clog2(FIFO_DEPTH):0] count;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ic_addr       = pc_q;
  assign ic_invalidate = fence_i;
  assign ic_req        = !rst && (!full || miss_q) && !fence_i;

  assign dec_valid = !empty;
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;

  assign wentry.pc    = pc_q;
  assign wentry.instr = ic_data;

  assign push = ic_valid && !disc_q && !redirect_valid && !full;
  assign pop  = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // The cache aborts its miss on invalidate, so fence clears both flags.
  always_comb begin
    miss_d = miss_q;
    if (redirect_valid && fence_i) begin
      miss_d = 1'b0;
    end else if (ic_valid) begin
      miss_d = 1'b0;
    end else if (ic_req && ic_stall) begin
      miss_d = 1'b1;
    end
  end

  // A response landing in the redirect cycle is the stale one itself,
  // so only a fresh stall arms another discard.
  always_comb begin
    disc_d = disc_q;
    if (redirect_valid) begin
      if (fence_i) begin
        disc_d = 1'b0;
      end else if (ic_valid) begin
        disc_d = ic_stall;
      end else begin
        disc_d = disc_q | miss_q | ic_stall;
      end
    end else if (ic_valid) begin
      disc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      miss_q <= 1'b0;
      disc_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      miss_q <= miss_d;
      disc_q <= disc_d;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning fetch buffer entries; legal values are powers of two, >=2.
REQ-003 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 redirect_valid  input  1  branch/jump/trap redirect pulse.
REQ-007 redirect_pc  input  32  new fetch PC when redirect_valid is high.
REQ-008 fence_i  input  1  FENCE.I pulse; always accompanied by redirect_valid.
REQ-009 ic_addr  output  32  instruction cache request address.
REQ-010 ic_req  output  1  instruction cache request.
REQ-011 ic_data  input  32  instruction cache read data.
REQ-012 ic_valid  input  1  ic_data valid this cycle.
REQ-013 ic_stall  input  1  cache miss in progress.
REQ-014 ic_invalidate  output  1  cache flush; combinational copy of fence_i.
REQ-015 dec_valid  output  1  buffer head valid.
REQ-016 dec_instr  output  32  head instruction.
REQ-017 dec_pc  output  32  head PC.
REQ-018 dec_ready  input  1  decode accepts the head this cycle.

Function
REQ-019 SHALL hold a 32-bit pc register; ic_addr SHALL equal pc at all times.
REQ-020 ic_req SHALL be high when (count < FIFO_DEPTH or miss_outstanding) and fence_i is low, where count is the number of buffered entries.
REQ-021 miss_outstanding SHALL set on a cycle with ic_req && ic_stall, and SHALL clear on a cycle with ic_valid.
REQ-022 An accepted response (ic_valid, not discarded, no redirect) SHALL push {pc, ic_data} and advance pc by pc+4 (mod 2^32) in the same cycle.
REQ-023 pc SHALL remain stable while a miss is outstanding; only redirect changes it.
REQ-024 The buffer SHALL pop on dec_valid && dec_ready; a simultaneous push and pop SHALL keep count unchanged; push SHALL never occur when full.
REQ-025 dec_valid SHALL be (count != 0); dec_instr and dec_pc SHALL present the oldest entry, with zero latency from push to head visibility on the next cycle.
REQ-026 On redirect_valid: flush the buffer (count=0), set pc<=redirect_pc, and drop any ic_valid in the same cycle; redirect SHALL have priority over push and pop.
REQ-027 Redirect with miss_outstanding, or with ic_stall high in that cycle and fence_i low, SHALL set discard_pending; the next ic_valid SHALL be dropped (pc unchanged) and SHALL clear discard_pending.
REQ-028 Redirect with fence_i SHALL clear miss_outstanding and discard_pending, because the cache aborts its miss on invalidate.
REQ-029 A second redirect while discard_pending is set SHALL keep a single pending discard.
REQ-030 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-031 During rst: pc=RESET_PC, count=0, buffer pointers=0, miss_outstanding=0, discard_pending=0.
REQ-032 Outputs during rst: dec_valid=0, ic_req=0, ic_invalidate=fence_i; dec_instr/dec_pc SHALL be don't-care.
REQ-033 rst mid-miss SHALL discard state; the first ic_valid after reset is for RESET_PC, since the cache is reset by the same rst.

Structure
REQ-034 A shared package SHALL hold XLEN=32, the instruction width, the RESET_PC default, and the fetch_entry_t {pc, instr} typedef.
REQ-035 The buffer SHALL be one sub-module, fetch_fifo: synchronous, parameterised depth, with push/pop/flush and an occupancy count; all other logic SHALL live in if_fetch_unit.

Verification
REQ-036 Reset with RESET_PC=0x100 and an always-hit cache (ic_valid=ic_req) -> dec_pc sequence 0x100, 0x104, 0x108; dec_instr matches the memory image.
REQ-037 dec_ready=0 for 5 cycles -> count saturates at 2, ic_req=0, pc=0x108; on dec_ready=1, ic_req reasserts the next cycle with no entry lost or duplicated.
REQ-038 Miss at 0x200 (ic_stall for 6 cycles), redirect to 0x400 on cycle 3 -> the response for 0x200 is dropped, and the first dec_pc is 0x400.
REQ-039 fence_i+redirect to 0x204 during a miss -> ic_invalidate=1 for 1 cycle, ic_req=0 that cycle, buffer empty, next fetch is 0x204, and no response is dropped.
REQ-040 pc=0xFFFF_FFF8 with hits -> dec_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-041 Redirect in the same cycle as ic_valid and dec_ready with the buffer full -> buffer empty next cycle, pc=redirect_pc, and the stale entry never reaches decode.
